chronologic: RTL and testbench
==============================

# chronologic

Request/grant liveness checker: every cycle `request` is sampled high opens an obligation that `grant` must be sampled high on some later cycle, at least one cycle after the request. The block counts outstanding obligations, measures their age and reports discharges. It flags optional bounded-wait timeouts and any obligations still open at end-of-test. It sits beside an arbiter or handshake interface as a synthesizable monitor feeding scoreboard and status logic.

## Interface
- `CNT_W`, 16: width of the outstanding, pass and fail counters.
- `AGE_W`, 16: width of the age counter.
- `MAX_WAIT`, 0: maximum cycles a grant may lag its oldest open request. 0 means unbounded, so no timeout is ever raised.
- `clk` in 1: sole clock. All logic samples on the rising edge.
- `rst` in 1: synchronous, active-high reset. Clears all state and abandons open obligations.
- `request` in 1: sampled each edge; high opens one obligation.
- `grant` in 1: sampled each edge; high discharges every obligation opened on earlier edges.
- `eot` in 1: end-of-test strobe; closes out all open obligations as failures.
- `outstanding` out CNT_W: number of open obligations.
- `pending` out 1: `outstanding != 0`.
- `age` out AGE_W: edges elapsed since the oldest open obligation was opened.
- `pass_valid` out 1: one-cycle pulse when a grant discharges at least one obligation.
- `pass_num` out CNT_W: obligations discharged on that edge. Holds 0 when `pass_valid` is low.
- `pass_total` out CNT_W: saturating count of discharged obligations.
- `timeout` out 1: one-cycle pulse on a bounded-wait violation.
- `unresolved` out 1: sticky; set when `eot` finds open obligations.
- `fail_total` out CNT_W: saturating count of obligations failed by timeout or `eot`.

## Operation
- All outputs are registered.
- Reset value of every output is 0. While `rst` is high, `request`, `grant` and `eot` are ignored.
- Per edge, with O = `outstanding` before the edge, steps are evaluated in this order:
  1. Discharge: if `grant`=1 and O>0, then `pass_valid`=1, `pass_num`=O, `pass_total`+=O (saturating), and O becomes 0.
  2. Timeout: applies only if `MAX_WAIT`>0, O>0 after step 1, and `age`==`MAX_WAIT`. Then `timeout`=1, `fail_total`+=O, and O becomes 0.
  3. New request: if `request`=1, O+=1, saturating at all-ones.
  4. End-of-test: if `eot`=1 and O>0 after step 3, then `unresolved`=1, `fail_total`+=O, and O becomes 0.
- A grant only discharges obligations opened on earlier edges. A request sampled together with a grant is not satisfied by that grant.
- A grant with no open obligation does nothing; `pass_valid` stays 0.
- `age`:
  - 0 if O is 0 after all steps.
  - Loads 0 when the oldest obligation is newly opened on this edge, i.e. O was 0 after step 2 and step 3 made it nonzero.
  - Otherwise increments, saturating at all-ones.
- Counter saturation is silent. `unresolved` is cleared only by `rst`.

## Timing
- Request sampled at edge t: `outstanding`=1 and `age`=0 visible after edge t.
- The earliest discharging grant is at edge t+1; `pass_valid` pulses in the cycle after edge t+1.
- Discharge latency is unbounded when `MAX_WAIT`=0.
- With `MAX_WAIT`=N, a grant at edge t+N is accepted. Without one, `timeout` pulses after edge t+N+1.
- Pulses (`pass_valid`, `timeout`) last exactly one cycle.
- Reset asserted mid-obligation clears state on the next edge with no fail and no pass.

## Test plan
- Request 1 at edge 2 only, grant 1 at edge 5:
  - after edge 2: `outstanding`=1;
  - after edge 4: `age`=2;
  - after edge 5: `pass_valid`=1, `pass_num`=1, `outstanding`=0, `pass_total`=1.
- Request at edges 2, 3, 4 and grant at edge 4:
  - after edge 4: `pass_num`=2, `outstanding`=1, `age`=0;
  - grant at edge 5 gives `pass_num`=1 and `pass_total`=3.
- Request and grant both 1 at edge 3 with nothing open: no pass, `outstanding`=1. Grant at edge 3 alone with nothing open: no pulse.
- `MAX_WAIT`=3, request at edge 1, no grant:
  - `timeout` pulses after edge 5;
  - `fail_total`=1, `outstanding`=0.
  - Repeating the run with grant at edge 4 passes instead.
- Requests at edges 1–2 and `eot` at edge 6, no grant: `unresolved`=1, `fail_total`=2, `outstanding`=0.
- Request at edges 1–3, `rst` at edge 4:
  - all outputs are 0 after edge 4;
  - `pass_total` and `fail_total` stay 0 even with grant at edge 5.

Source files
------------

// File: rtl/chronologic.sv
// Request/grant liveness monitor: tracks open obligations, their age, discharges,
// bounded-wait timeouts and obligations left open at end-of-test.
module chronologic #(
    parameter int CNT_W    = 16,
    parameter int AGE_W    = 16,
    parameter int MAX_WAIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             request,
    input  logic             grant,
    input  logic             eot,
    output logic [CNT_W-1:0] outstanding,
    output logic             pending,
    output logic [AGE_W-1:0] age,
    output logic             pass_valid,
    output logic [CNT_W-1:0] pass_num,
    output logic [CNT_W-1:0] pass_total,
    output logic             timeout,
    output logic             unresolved,
    output logic [CNT_W-1:0] fail_total
);

    localparam bit               HAS_WAIT = (MAX_WAIT > 0);
    localparam logic [AGE_W-1:0] WAIT_LIM = AGE_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0] out_nxt;
    logic [AGE_W-1:0] age_nxt;
    logic             pv_nxt;
    logic [CNT_W-1:0] pn_nxt;
    logic [CNT_W-1:0] pt_nxt;
    logic             to_nxt;
    logic             un_nxt;
    logic [CNT_W-1:0] ft_nxt;
    logic             fresh;

    // Discharge, timeout, new request and end-of-test are applied in that order.
    always_comb begin
        out_nxt = outstanding;
        age_nxt = '0;
        pv_nxt  = 1'b0;
        pn_nxt  = '0;
        pt_nxt  = pass_total;
        to_nxt  = 1'b0;
        un_nxt  = unresolved;
        ft_nxt  = fail_total;
        fresh   = 1'b0;

        if (grant && (outstanding != '0)) begin
            pv_nxt  = 1'b1;
            pn_nxt  = outstanding;
            pt_nxt  = sat_add(pass_total, outstanding);
            out_nxt = '0;
        end

        if (HAS_WAIT && (out_nxt != '0) && (age == WAIT_LIM)) begin
            to_nxt  = 1'b1;
            ft_nxt  = sat_add(ft_nxt, out_nxt);
            out_nxt = '0;
        end

        // A request landing on an empty set becomes the new oldest obligation.
        fresh = (out_nxt == '0);
        if (request && (out_nxt != CNT_MAX)) begin
            out_nxt = out_nxt + 1'b1;
        end

        if (eot && (out_nxt != '0)) begin
            un_nxt  = 1'b1;
            ft_nxt  = sat_add(ft_nxt, out_nxt);
            out_nxt = '0;
        end

        if ((out_nxt == '0) || fresh) begin
            age_nxt = '0;
        end else if (age != AGE_MAX) begin
            age_nxt = age + 1'b1;
        end else begin
            age_nxt = age;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            pending     <= 1'b0;
            age         <= '0;
            pass_valid  <= 1'b0;
            pass_num    <= '0;
            pass_total  <= '0;
            timeout     <= 1'b0;
            unresolved  <= 1'b0;
            fail_total  <= '0;
        end else begin
            outstanding <= out_nxt;
            pending     <= (out_nxt != '0);
            age         <= age_nxt;
            pass_valid  <= pv_nxt;
            pass_num    <= pn_nxt;
            pass_total  <= pt_nxt;
            timeout     <= to_nxt;
            unresolved  <= un_nxt;
            fail_total  <= ft_nxt;
        end
    end

endmodule

// File: tb/tb_chronologic.sv
// Bench for chronologic: three parameterisations driven together, checked every
// cycle against an arithmetic obligation model, plus hand-computed directed cases.
module tb_chronologic;

    logic clk = 1'b0;
    logic rst, request, grant, eot;

    always #5 clk = ~clk;

    // dut a: unbounded, wide; dut b: MAX_WAIT=3, 4-bit; dut c: unbounded, 3-bit (saturation)
    logic [15:0] a_out, a_age, a_pn, a_pt, a_ft;
    logic        a_pend, a_pv, a_to, a_un;
    logic [3:0]  b_out, b_age, b_pn, b_pt, b_ft;
    logic        b_pend, b_pv, b_to, b_un;
    logic [2:0]  c_out, c_age, c_pn, c_pt, c_ft;
    logic        c_pend, c_pv, c_to, c_un;

    chronologic #(.CNT_W(16), .AGE_W(16), .MAX_WAIT(0)) dut_a (
        .clk(clk), .rst(rst), .request(request), .grant(grant), .eot(eot),
        .outstanding(a_out), .pending(a_pend), .age(a_age), .pass_valid(a_pv),
        .pass_num(a_pn), .pass_total(a_pt), .timeout(a_to), .unresolved(a_un),
        .fail_total(a_ft));

    chronologic #(.CNT_W(4), .AGE_W(4), .MAX_WAIT(3)) dut_b (
        .clk(clk), .rst(rst), .request(request), .grant(grant), .eot(eot),
        .outstanding(b_out), .pending(b_pend), .age(b_age), .pass_valid(b_pv),
        .pass_num(b_pn), .pass_total(b_pt), .timeout(b_to), .unresolved(b_un),
        .fail_total(b_ft));

    chronologic #(.CNT_W(3), .AGE_W(3), .MAX_WAIT(0)) dut_c (
        .clk(clk), .rst(rst), .request(request), .grant(grant), .eot(eot),
        .outstanding(c_out), .pending(c_pend), .age(c_age), .pass_valid(c_pv),
        .pass_num(c_pn), .pass_total(c_pt), .timeout(c_to), .unresolved(c_un),
        .fail_total(c_ft));

    logic [63:0] d_out[3], d_age[3], d_pn[3], d_pt[3], d_ft[3];
    logic [63:0] d_pend[3], d_pv[3], d_to[3], d_un[3];

    always_comb begin
        d_out[0] = 64'(a_out); d_age[0] = 64'(a_age); d_pn[0] = 64'(a_pn);
        d_pt[0]  = 64'(a_pt);  d_ft[0]  = 64'(a_ft);  d_pend[0] = 64'(a_pend);
        d_pv[0]  = 64'(a_pv);  d_to[0]  = 64'(a_to);  d_un[0]   = 64'(a_un);
        d_out[1] = 64'(b_out); d_age[1] = 64'(b_age); d_pn[1] = 64'(b_pn);
        d_pt[1]  = 64'(b_pt);  d_ft[1]  = 64'(b_ft);  d_pend[1] = 64'(b_pend);
        d_pv[1]  = 64'(b_pv);  d_to[1]  = 64'(b_to);  d_un[1]   = 64'(b_un);
        d_out[2] = 64'(c_out); d_age[2] = 64'(c_age); d_pn[2] = 64'(c_pn);
        d_pt[2]  = 64'(c_pt);  d_ft[2]  = 64'(c_ft);  d_pend[2] = 64'(c_pend);
        d_pv[2]  = 64'(c_pv);  d_to[2]  = 64'(c_to);  d_un[2]   = 64'(c_un);
    end

    // Reference model: counts of open obligations as plain integers.
    longint cmax[3] = '{65535, 15, 7};
    longint amax[3] = '{65535, 15, 7};
    longint mwait[3] = '{0, 3, 0};
    longint m_out[3], m_age[3], m_pn[3], m_pt[3], m_ft[3];
    bit     m_pv[3], m_to[3], m_un[3];

    function automatic longint lmin(input longint x, input longint y);
        return (x < y) ? x : y;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            longint o, pt, ft, ag, pn;
            bit pv, tmo, un, was_empty;
            if (rst) begin
                m_out[i] <= 0; m_age[i] <= 0; m_pn[i] <= 0; m_pt[i] <= 0;
                m_ft[i] <= 0;  m_pv[i] <= 0;  m_to[i] <= 0; m_un[i] <= 0;
            end else begin
                o = m_out[i]; pt = m_pt[i]; ft = m_ft[i]; un = m_un[i];
                pv = 0; pn = 0; tmo = 0;
                if (grant && o > 0) begin
                    pv = 1; pn = o; pt = lmin(pt + o, cmax[i]); o = 0;
                end
                if (mwait[i] > 0 && o > 0 && m_age[i] == mwait[i]) begin
                    tmo = 1; ft = lmin(ft + o, cmax[i]); o = 0;
                end
                was_empty = (o == 0);
                if (request) o = lmin(o + 1, cmax[i]);
                if (eot && o > 0) begin
                    un = 1; ft = lmin(ft + o, cmax[i]); o = 0;
                end
                ag = (o == 0 || was_empty) ? 0 : lmin(m_age[i] + 1, amax[i]);
                m_out[i] <= o; m_age[i] <= ag; m_pn[i] <= pn; m_pt[i] <= pt;
                m_ft[i] <= ft; m_pv[i] <= pv; m_to[i] <= tmo; m_un[i] <= un;
            end
        end
    end

    int nvec = 0;
    int nmis = 0;
    bit chk_en = 0;

    task automatic cmp(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", nm, idx, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                cmp("outstanding", i, d_out[i], 64'(m_out[i]));
                cmp("pending", i, d_pend[i], 64'(m_out[i] != 0));
                cmp("age", i, d_age[i], 64'(m_age[i]));
                cmp("pass_valid", i, d_pv[i], 64'(m_pv[i]));
                cmp("pass_num", i, d_pn[i], 64'(m_pn[i]));
                cmp("pass_total", i, d_pt[i], 64'(m_pt[i]));
                cmp("timeout", i, d_to[i], 64'(m_to[i]));
                cmp("unresolved", i, d_un[i], 64'(m_un[i]));
                cmp("fail_total", i, d_ft[i], 64'(m_ft[i]));
            end
        end
    end

    task automatic step(input bit r, input bit q, input bit g, input bit e);
        rst = r; request = q; grant = g; eot = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0);
        chk_en = 1;
    endtask

    initial begin
        int gp;
        rst = 1; request = 0; grant = 0; eot = 0;
        do_reset();
        cmp("lit_reset_out", 0, 64'(a_out), 0);
        cmp("lit_reset_ft", 0, 64'(a_ft), 0);

        // request at edge 2, grant at edge 5
        do_reset();
        step(0, 0, 0, 0); step(0, 1, 0, 0);
        cmp("lit_t1_out_e2", 0, 64'(a_out), 1);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        cmp("lit_t1_age_e4", 0, 64'(a_age), 2);
        step(0, 0, 1, 0);
        cmp("lit_t1_pv", 0, 64'(a_pv), 1);
        cmp("lit_t1_pn", 0, 64'(a_pn), 1);
        cmp("lit_t1_out", 0, 64'(a_out), 0);
        cmp("lit_t1_pt", 0, 64'(a_pt), 1);
        step(0, 0, 0, 0);
        cmp("lit_t1_pv_pulse", 0, 64'(a_pv), 0);

        // requests at edges 2-4, grants at edges 4 and 5
        do_reset();
        step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 1, 0);
        cmp("lit_t2_pn_e4", 0, 64'(a_pn), 2);
        cmp("lit_t2_out_e4", 0, 64'(a_out), 1);
        cmp("lit_t2_age_e4", 0, 64'(a_age), 0);
        step(0, 0, 1, 0);
        cmp("lit_t2_pn_e5", 0, 64'(a_pn), 1);
        cmp("lit_t2_pt_e5", 0, 64'(a_pt), 3);

        // request with grant on empty set; then lone grant
        do_reset();
        step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 1, 1, 0);
        cmp("lit_t3_pv", 0, 64'(a_pv), 0);
        cmp("lit_t3_out", 0, 64'(a_out), 1);
        do_reset();
        step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 1, 0);
        cmp("lit_t3_lone_pv", 0, 64'(a_pv), 0);

        // MAX_WAIT=3 timeout, then the same run rescued by a grant at edge 4
        do_reset();
        step(0, 1, 0, 0);
        for (int k = 2; k <= 4; k++) step(0, 0, 0, 0);
        cmp("lit_t4_to_e4", 1, 64'(b_to), 0);
        step(0, 0, 0, 0);
        cmp("lit_t4_to_e5", 1, 64'(b_to), 1);
        cmp("lit_t4_ft", 1, 64'(b_ft), 1);
        cmp("lit_t4_out", 1, 64'(b_out), 0);
        step(0, 0, 0, 0);
        cmp("lit_t4_to_e6", 1, 64'(b_to), 0);
        do_reset();
        step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 1, 0);
        cmp("lit_t4b_pv", 1, 64'(b_pv), 1);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        cmp("lit_t4b_to", 1, 64'(b_to), 0);
        cmp("lit_t4b_ft", 1, 64'(b_ft), 0);

        // end-of-test with two open obligations
        do_reset();
        step(0, 1, 0, 0); step(0, 1, 0, 0);
        for (int k = 3; k <= 5; k++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        cmp("lit_t5_un", 0, 64'(a_un), 1);
        cmp("lit_t5_ft", 0, 64'(a_ft), 2);
        cmp("lit_t5_out", 0, 64'(a_out), 0);

        // reset mid-obligation
        do_reset();
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        cmp("lit_t6_out", 0, 64'(a_out), 0);
        cmp("lit_t6_age", 0, 64'(a_age), 0);
        cmp("lit_t6_pend", 0, 64'(a_pend), 0);
        step(0, 0, 1, 0);
        cmp("lit_t6_pt", 0, 64'(a_pt), 0);
        cmp("lit_t6_ft", 0, 64'(a_ft), 0);
        cmp("lit_t6_pv", 0, 64'(a_pv), 0);

        // saturation on the 3-bit instance
        do_reset();
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0);
        cmp("lit_sat_out", 2, 64'(c_out), 7);
        cmp("lit_sat_age", 2, 64'(c_age), 7);
        step(0, 0, 1, 0);
        cmp("lit_sat_pn", 2, 64'(c_pn), 7);
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        cmp("lit_sat_pt", 2, 64'(c_pt), 7);

        // randomized phases with varying grant density
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            case (seg)
                0: gp = 25;
                1: gp = 2;
                2: gp = 50;
                3: gp = 0;
                4: gp = 10;
                default: gp = 5;
            endcase
            for (int k = 0; k < 500; k++) begin
                step($urandom_range(0, 249) == 0,
                     $urandom_range(0, 99) < 60,
                     $urandom_range(0, 99) < gp,
                     $urandom_range(0, 149) == 0);
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
